// File: rtl/bcd_pkg.sv
// Shared constants for the digit-serial BCD adder.
// Digit width, BCD limits and FSM state encodings.
package bcd_pkg;
  localparam int         BCD_DIGIT_W = 4;
  localparam logic [3:0] BCD_MAX     = 4'd9;
  localparam logic [3:0] BCD_CORR    = 4'd6;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ADD  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;
endpackage

// File: rtl/bcd_digit_adder.sv
// One-digit BCD adder with decimal carry correction.
// Non-BCD inputs follow the same rule, deterministically.
module bcd_digit_adder
  import bcd_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);

  logic [4:0] t;
  logic [4:0] t_corr;

  always_comb begin
    t      = {1'b0, a} + {1'b0, b} + {4'b0, cin};
    t_corr = t + {1'b0, BCD_CORR};
    if (t > {1'b0, BCD_MAX}) begin
      s    = t_corr[3:0];
      cout = 1'b1;
    end else begin
      s    = t[3:0];
      cout = 1'b0;
    end
  end

endmodule

// File: rtl/bcd_serial_adder.sv
// Digit-serial multi-digit BCD adder, LSD first.
// One shared digit adder; carry held between digits.
module bcd_serial_adder
  import bcd_pkg::*;
#(
  parameter  int DIGITS = 4,
  localparam int DW     = 4 * DIGITS
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [DW-1:0] A,
  input  logic [DW-1:0] B,
  input  logic          Cin,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] S,
  output logic          Cout,
  output logic          err
);

  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);

  logic [1:0]    state;
  logic [DW-1:0] a_sr;
  logic [DW-1:0] b_sr;
  logic          carry_reg;
  logic [IW-1:0] idx;

  logic [3:0]    dsum;
  logic          dcout;
  logic [DW-1:0] s_next;
  logic          bad;

  bcd_digit_adder u_digit (
    .a    (a_sr[3:0]),
    .b    (b_sr[3:0]),
    .cin  (carry_reg),
    .s    (dsum),
    .cout (dcout)
  );

  // New digit enters at the top; after DIGITS shifts digit 0 is at S[3:0].
  always_comb begin
    s_next = S >> BCD_DIGIT_W;
    s_next[DW-1 -: 4] = dsum;
  end

  always_comb begin
    bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (A[4*i +: 4] > BCD_MAX) bad = 1'b1;
      if (B[4*i +: 4] > BCD_MAX) bad = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      a_sr      <= '0;
      b_sr      <= '0;
      carry_reg <= 1'b0;
      idx       <= '0;
      S         <= '0;
      Cout      <= 1'b0;
      err       <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            a_sr      <= A;
            b_sr      <= B;
            carry_reg <= Cin;
            idx       <= '0;
            err       <= bad;
            S         <= '0;
            Cout      <= 1'b0;
            state     <= ST_ADD;
          end
        end
        ST_ADD: begin
          S         <= s_next;
          carry_reg <= dcout;
          a_sr      <= a_sr >> BCD_DIGIT_W;
          b_sr      <= b_sr >> BCD_DIGIT_W;
          idx       <= idx + IW'(1);
          if (idx == LAST) begin
            Cout  <= dcout;
            state <= ST_DONE;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy = (state == ST_ADD);
  assign done = (state == ST_DONE);

endmodule

// File: tb/tb_bcd_serial_adder.sv
// Directed self-checking bench for bcd_serial_adder.
// Each task drives one scenario and checks inline.
module tb_bcd_serial_adder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] A = '0;
  logic [15:0] B = '0;
  logic        Cin = 1'b0;
  logic        busy;
  logic        done;
  logic [15:0] S;
  logic        Cout;
  logic        err;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  bcd_serial_adder #(.DIGITS(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (A),
    .B     (B),
    .Cin   (Cin),
    .busy  (busy),
    .done  (done),
    .S     (S),
    .Cout  (Cout),
    .err   (err)
  );

  // Issue one start, scramble inputs after acceptance, watch 10 cycles.
  // Cycle 1 is the cycle right after the start edge.
  task automatic run_op(
    input  logic [15:0] a, input logic [15:0] b, input logic c,
    output int lat, output int busy_cnt, output int done_cnt,
    output logic [15:0] s_at1
  );
    lat = 0; busy_cnt = 0; done_cnt = 0; s_at1 = 'x;
    @(posedge clk); #1;
    A = a; B = b; Cin = c; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; A = 16'hFFFF; B = 16'hFFFF; Cin = 1'b1;
    for (int cyc = 1; cyc <= 10; cyc++) begin
      if (cyc == 1) s_at1 = S;
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (lat == 0) lat = cyc;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passed++;
    total++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else passed++;
    total++; if (S !== 16'h0) $display("FAIL reset_S got %h want 0000", S); else passed++;
    total++; if (Cout !== 1'b0) $display("FAIL reset_Cout got %b want 0", Cout); else passed++;
    total++; if (err !== 1'b0) $display("FAIL reset_err got %b want 0", err); else passed++;
    rst = 1'b0;
    A = 16'h1111; B = 16'h2222;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      total++;
      if (busy !== 1'b0 || done !== 1'b0 || S !== 16'h0)
        $display("FAIL idle_quiet got busy=%b done=%b S=%h want 0 0 0000", busy, done, S);
      else passed++;
    end
  endtask

  task automatic test_basic();
    int lat, bc, dc; logic [15:0] s1;
    run_op(16'h1234, 16'h5678, 1'b0, lat, bc, dc, s1);
    total++; if (lat != 5) $display("FAIL basic_latency got %0d want 5", lat); else passed++;
    total++; if (bc != 4) $display("FAIL basic_busy_cycles got %0d want 4", bc); else passed++;
    total++; if (dc != 1) $display("FAIL basic_done_pulses got %0d want 1", dc); else passed++;
    total++; if (S !== 16'h6912) $display("FAIL basic_S got %h want 6912", S); else passed++;
    total++; if (Cout !== 1'b0) $display("FAIL basic_Cout got %b want 0", Cout); else passed++;
    total++; if (err !== 1'b0) $display("FAIL basic_err got %b want 0", err); else passed++;
    repeat (3) @(posedge clk);
    #1;
    total++; if (S !== 16'h6912) $display("FAIL basic_S_held got %h want 6912", S); else passed++;
  endtask

  task automatic test_carry();
    int lat, bc, dc; logic [15:0] s1;
    run_op(16'h9999, 16'h0001, 1'b0, lat, bc, dc, s1);
    total++; if (s1 !== 16'h0000) $display("FAIL carry_S_cleared got %h want 0000", s1); else passed++;
    total++; if (S !== 16'h0000) $display("FAIL ripple_S got %h want 0000", S); else passed++;
    total++; if (Cout !== 1'b1) $display("FAIL ripple_Cout got %b want 1", Cout); else passed++;
    run_op(16'h9999, 16'h9999, 1'b1, lat, bc, dc, s1);
    total++; if (S !== 16'h9999) $display("FAIL max_S got %h want 9999", S); else passed++;
    total++; if (Cout !== 1'b1) $display("FAIL max_Cout got %b want 1", Cout); else passed++;
    total++; if (dc != 1) $display("FAIL max_done_pulses got %0d want 1", dc); else passed++;
  endtask

  task automatic test_invalid();
    int lat, bc, dc; logic [15:0] s1;
    run_op(16'h12A4, 16'h0000, 1'b0, lat, bc, dc, s1);
    total++; if (err !== 1'b1) $display("FAIL inv_err got %b want 1", err); else passed++;
    total++; if (S !== 16'h1304) $display("FAIL inv_S got %h want 1304", S); else passed++;
    total++; if (Cout !== 1'b0) $display("FAIL inv_Cout got %b want 0", Cout); else passed++;
    total++; if (dc != 1) $display("FAIL inv_done_pulses got %0d want 1", dc); else passed++;
    total++; if (lat != 5) $display("FAIL inv_latency got %0d want 5", lat); else passed++;
  endtask

  task automatic test_ignore_start();
    int dc = 0;
    @(posedge clk); #1;
    A = 16'h1111; B = 16'h2222; Cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int cyc = 1; cyc <= 10; cyc++) begin
      if (cyc == 2) begin
        A = 16'h4444; B = 16'h4444; Cin = 1'b1; start = 1'b1;
      end
      if (cyc == 3) start = 1'b0;
      if (done) dc++;
      @(posedge clk); #1;
    end
    total++; if (S !== 16'h3333) $display("FAIL ignore_S got %h want 3333", S); else passed++;
    total++; if (Cout !== 1'b0) $display("FAIL ignore_Cout got %b want 0", Cout); else passed++;
    total++; if (dc != 1) $display("FAIL ignore_done_pulses got %0d want 1", dc); else passed++;
    total++; if (err !== 1'b0) $display("FAIL ignore_err got %b want 0", err); else passed++;
  endtask

  task automatic test_reset_abort();
    int lat, bc, dc; logic [15:0] s1;
    dc = 0;
    @(posedge clk); #1;
    A = 16'h9999; B = 16'h9999; Cin = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    total++; if (busy !== 1'b1) $display("FAIL abort_busy_before got %b want 1", busy); else passed++;
    rst = 1'b1;
    @(posedge clk); #1;
    total++; if (busy !== 1'b0) $display("FAIL abort_busy got %b want 0", busy); else passed++;
    total++; if (S !== 16'h0) $display("FAIL abort_S got %h want 0000", S); else passed++;
    total++; if (Cout !== 1'b0) $display("FAIL abort_Cout got %b want 0", Cout); else passed++;
    total++; if (err !== 1'b0) $display("FAIL abort_err got %b want 0", err); else passed++;
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (done) dc++;
      @(posedge clk); #1;
    end
    total++; if (dc != 0) $display("FAIL abort_no_done got %0d want 0", dc); else passed++;
    run_op(16'h1234, 16'h5678, 1'b0, lat, bc, dc, s1);
    total++; if (S !== 16'h6912) $display("FAIL after_abort_S got %h want 6912", S); else passed++;
    total++; if (dc != 1) $display("FAIL after_abort_done got %0d want 1", dc); else passed++;
    total++; if (lat != 5) $display("FAIL after_abort_latency got %0d want 5", lat); else passed++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_carry();
    test_invalid();
    test_ignore_start();
    test_reset_abort();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
